// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
// Entry state encoding and destination field position.
package rob_pkg;

   localparam logic [1:0] ST_FREE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DEST_LSB = 7;
   localparam int DEST_MSB = 11;

endpackage

// File: rtl/reorder_buffer_if.sv
// Allocation, CDB, flush, commit and status bundle.
// The ROB sits on the slave side.
interface reorder_buffer_if #(
   parameter int DEPTH   = 8,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4,
   parameter int INSTR_W = 32
);

   localparam int PTR_W = $clog2(DEPTH);

   logic               alloc_valid;
   logic               alloc_ready;
   logic [INSTR_W-1:0] alloc_instr;
   logic [TAG_W-1:0]   alloc_tag;
   logic [PTR_W-1:0]   alloc_idx;
   logic               cdb_valid;
   logic [TAG_W-1:0]   cdb_tag;
   logic [DATA_W-1:0]  cdb_value;
   logic               flush;
   logic               commit_valid;
   logic               commit_we;
   logic [4:0]         commit_dest;
   logic [DATA_W-1:0]  commit_value;
   logic               full;
   logic               empty;
   logic [PTR_W:0]     count;

   modport master (
      output alloc_valid, alloc_instr, alloc_tag,
      output cdb_valid, cdb_tag, cdb_value, flush,
      input  alloc_ready, alloc_idx,
      input  commit_valid, commit_we,
      input  commit_dest, commit_value,
      input  full, empty, count
   );

   modport slave (
      input  alloc_valid, alloc_instr, alloc_tag,
      input  cdb_valid, cdb_tag, cdb_value, flush,
      output alloc_ready, alloc_idx,
      output commit_valid, commit_we,
      output commit_dest, commit_value,
      output full, empty, count
   );

endinterface

// File: rtl/rob_slot.sv
// One reorder buffer entry: state, instr, tag, value.
// Snoops the CDB and captures on a tag match while waiting.
module rob_slot
   import rob_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alloc_we,
   input  logic [INSTR_W-1:0] alloc_instr,
   input  logic [TAG_W-1:0]   alloc_tag,
   input  logic               cdb_valid,
   input  logic [TAG_W-1:0]   cdb_tag,
   input  logic [DATA_W-1:0]  cdb_value,
   input  logic               clear,
   output logic [1:0]         state,
   output logic [TAG_W-1:0]   tag,
   output logic [DATA_W-1:0]  value,
   output logic [4:0]         dest
);

   logic [1:0]         state_q;
   logic [INSTR_W-1:0] instr_q;
   logic [TAG_W-1:0]   tag_q;
   logic [DATA_W-1:0]  value_q;
   logic               match;
   logic               instr_unused;

   assign match = cdb_valid
               && (state_q == ST_WAIT)
               && (tag_q == cdb_tag);

   // Entry lifecycle; clear wins so a retiring bypass entry frees.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FREE;
         instr_q <= '0;
         tag_q   <= '0;
         value_q <= '0;
      end else if (clear) begin
         state_q <= ST_FREE;
         instr_q <= '0;
         tag_q   <= '0;
         value_q <= '0;
      end else if (alloc_we) begin
         state_q <= ST_WAIT;
         instr_q <= alloc_instr;
         tag_q   <= alloc_tag;
         value_q <= '0;
      end else if (match) begin
         state_q <= ST_DONE;
         value_q <= cdb_value;
      end
   end

   assign state = state_q;
   assign tag   = tag_q;
   assign value = value_q;
   assign dest  = instr_q[DEST_MSB:DEST_LSB];

   assign instr_unused = ^{instr_q[INSTR_W-1:DEST_MSB+1],
                           instr_q[DEST_LSB-1:0]};

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer with CDB capture and in-order commit.
// Head/tail/count and commit muxing; entries live in rob_slot.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4,
   parameter int INSTR_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   reorder_buffer_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W:0]    cnt;

   logic [1:0]        st  [DEPTH];
   logic [TAG_W-1:0]  tg  [DEPTH];
   logic [DATA_W-1:0] val [DEPTH];
   logic [4:0]        dst [DEPTH];
   logic [DEPTH-1:0]  wr;
   logic [DEPTH-1:0]  clr;

   logic              full;
   logic              bypass;
   logic              commit_fire;
   logic              alloc_fire;
   logic [4:0]        c_dest;
   logic [DATA_W-1:0] c_value;

   assign full = (cnt == CNT_MAX);

   // Head retirement decision, CDB bypass and output gating.
   always_comb begin
      bypass      = 1'b0;
      commit_fire = 1'b0;
      c_dest      = '0;
      c_value     = '0;
      bypass = (st[head] == ST_WAIT)
            && bus.cdb_valid
            && (tg[head] == bus.cdb_tag);
      commit_fire = ((st[head] == ST_DONE) || bypass)
                 && !bus.flush;
      if (commit_fire) begin
         c_dest  = dst[head];
         c_value = bypass ? bus.cdb_value : val[head];
      end
   end

   assign alloc_fire = bus.alloc_valid && !full && !bus.flush;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      assign wr[i]  = alloc_fire && (tail == PTR_W'(i));
      assign clr[i] = bus.flush
                   || (commit_fire && (head == PTR_W'(i)));

      rob_slot #(
         .DATA_W  (DATA_W),
         .TAG_W   (TAG_W),
         .INSTR_W (INSTR_W)
      ) u_slot (
         .clk         (clk),
         .rst         (rst),
         .alloc_we    (wr[i]),
         .alloc_instr (bus.alloc_instr),
         .alloc_tag   (bus.alloc_tag),
         .cdb_valid   (bus.cdb_valid),
         .cdb_tag     (bus.cdb_tag),
         .cdb_value   (bus.cdb_value),
         .clear       (clr[i]),
         .state       (st[i]),
         .tag         (tg[i]),
         .value       (val[i]),
         .dest        (dst[i])
      );
   end

   // Pointers and occupancy; flush returns to the reset layout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (bus.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (commit_fire) head <= head + 1'b1;
         if (alloc_fire)  tail <= tail + 1'b1;
         cnt <= cnt
              + (PTR_W+1)'(alloc_fire)
              - (PTR_W+1)'(commit_fire);
      end
   end

   assign bus.alloc_ready  = !full;
   assign bus.alloc_idx    = tail;
   assign bus.commit_valid = commit_fire;
   assign bus.commit_we    = commit_fire && (c_dest != 5'd0);
   assign bus.commit_dest  = c_dest;
   assign bus.commit_value = c_value;
   assign bus.full         = full;
   assign bus.empty        = (cnt == '0);
   assign bus.count        = cnt;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer.
// Queue-based reference model; monitor checks each retirement.
module tb_reorder_buffer;

   localparam int DEPTH   = 8;
   localparam int DATA_W  = 32;
   localparam int TAG_W   = 4;
   localparam int INSTR_W = 32;

   typedef struct {
      logic [4:0]  dest;
      logic [3:0]  tag;
      bit          done;
      logic [31:0] value;
   } ent_t;

   typedef struct {
      logic [4:0]  dest;
      logic [31:0] value;
      bit          we;
   } cmt_t;

   logic clk = 1'b0;
   logic rst;

   ent_t mq[$];
   cmt_t exp_q[$];
   int   tl;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   reorder_buffer_if #(
      .DEPTH(DEPTH), .DATA_W(DATA_W),
      .TAG_W(TAG_W), .INSTR_W(INSTR_W)
   ) bus ();

   reorder_buffer #(
      .DEPTH(DEPTH), .DATA_W(DATA_W),
      .TAG_W(TAG_W), .INSTR_W(INSTR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rd);
      logic [31:0] r;
      r = $urandom;
      return {r[31:12], rd, r[6:0]};
   endfunction

   // Monitor: every retirement the DUT shows is popped and compared
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.commit_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL commit_extra: got dest %0d want none",
                     bus.commit_dest);
         end else begin
            cmt_t c;
            c = exp_q.pop_front();
            chk("commit_dest", 64'(bus.commit_dest), 64'(c.dest));
            chk("commit_value", 64'(bus.commit_value), 64'(c.value));
            chk("commit_we_mon", 64'(bus.commit_we), 64'(c.we));
         end
      end
   end

   task automatic idle_inputs();
      bus.alloc_valid = 1'b0;
      bus.alloc_instr = '0;
      bus.alloc_tag   = '0;
      bus.cdb_valid   = 1'b0;
      bus.cdb_tag     = '0;
      bus.cdb_value   = '0;
      bus.flush       = 1'b0;
   endtask

   task automatic step(input bit av, input logic [31:0] ins,
                       input logic [3:0] at, input bit cv,
                       input logic [3:0] ct, input logic [31:0] cvl,
                       input bit fl);
      bit   ready;
      bit   cm;
      bit   cwe;
      cmt_t c;
      ent_t e;
      @(posedge clk);
      #1;
      bus.alloc_valid = av;
      bus.alloc_instr = ins;
      bus.alloc_tag   = at;
      bus.cdb_valid   = cv;
      bus.cdb_tag     = ct;
      bus.cdb_value   = cvl;
      bus.flush       = fl;
      ready = mq.size() < DEPTH;
      cm = !fl && mq.size() > 0
        && (mq[0].done || (cv && mq[0].tag == ct));
      cwe = 1'b0;
      if (cm) begin
         c.dest  = mq[0].dest;
         c.value = mq[0].done ? mq[0].value : cvl;
         c.we    = (c.dest != 5'd0);
         cwe     = c.we;
         exp_q.push_back(c);
      end
      @(negedge clk);
      chk("alloc_ready", 64'(bus.alloc_ready), 64'(ready));
      chk("full", 64'(bus.full), 64'(!ready));
      chk("empty", 64'(bus.empty), 64'(mq.size() == 0));
      chk("count", 64'(bus.count), 64'(mq.size()));
      chk("alloc_idx", 64'(bus.alloc_idx), 64'(tl));
      chk("commit_valid", 64'(bus.commit_valid), 64'(cm));
      chk("commit_we", 64'(bus.commit_we), 64'(cwe));
      if (!cm) begin
         chk("idle_dest", 64'(bus.commit_dest), 64'(0));
         chk("idle_value", 64'(bus.commit_value), 64'(0));
      end
      if (fl) begin
         mq.delete();
         tl = 0;
      end else begin
         if (cv) begin
            foreach (mq[i]) begin
               if (!mq[i].done && mq[i].tag == ct) begin
                  mq[i].done  = 1'b1;
                  mq[i].value = cvl;
               end
            end
         end
         if (cm) void'(mq.pop_front());
         if (av && ready) begin
            e.dest  = ins[11:7];
            e.tag   = at;
            e.done  = 1'b0;
            e.value = '0;
            mq.push_back(e);
            tl = (tl + 1) % DEPTH;
         end
      end
   endtask

   task automatic alloc(input logic [4:0] rd, input logic [3:0] t);
      step(1'b1, mk(rd), t, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] v);
      step(1'b0, 32'h0, 4'h0, 1'b1, t, v, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic do_flush();
      step(1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1);
   endtask

   task automatic reset_checks(input string tagname);
      chk({tagname, "_empty"}, 64'(bus.empty), 64'(1));
      chk({tagname, "_full"}, 64'(bus.full), 64'(0));
      chk({tagname, "_count"}, 64'(bus.count), 64'(0));
      chk({tagname, "_ready"}, 64'(bus.alloc_ready), 64'(1));
      chk({tagname, "_cvalid"}, 64'(bus.commit_valid), 64'(0));
      chk({tagname, "_cwe"}, 64'(bus.commit_we), 64'(0));
      chk({tagname, "_cdest"}, 64'(bus.commit_dest), 64'(0));
      chk({tagname, "_cvalue"}, 64'(bus.commit_value), 64'(0));
      chk({tagname, "_idx"}, 64'(bus.alloc_idx), 64'(0));
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2;
      idle_inputs();
      #1;
      rst = 1'b1;
      #1;
      reset_checks("async_rst");
      mq.delete();
      exp_q.delete();
      tl = 0;
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      tl  = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      reset_checks("reset");
      #1;
      rst = 1'b0;

      alloc(5'd5, 4'd1);
      alloc(5'd6, 4'd2);
      alloc(5'd7, 4'd3);
      cdb(4'd2, 32'hAA);
      cdb(4'd1, 32'h55);
      idle();
      idle();

      do_flush();
      for (int i = 0; i < DEPTH; i++)
         alloc(5'(i + 1), 4'(i + 8));
      step(1'b1, mk(5'd20), 4'd1, 1'b1, 4'd8, 32'h1234, 1'b0);
      alloc(5'd21, 4'd2);
      idle();

      do_flush();
      alloc(5'd0, 4'd5);
      cdb(4'd5, 32'hDEAD);
      idle();

      do_flush();
      for (int i = 0; i < 5; i++)
         alloc(5'(i + 10), 4'(i + 1));
      cdb(4'd2, 32'h22);
      step(1'b1, mk(5'd9), 4'd6, 1'b1, 4'd1, 32'h11, 1'b1);
      idle();

      for (int i = 0; i < 4; i++)
         alloc(5'(i + 3), 4'(i));
      async_reset();
      alloc(5'd4, 4'd4);
      idle();

      for (int n = 0; n < 400; n++) begin
         bit          av;
         bit          cv;
         bit          fl;
         logic [3:0]  ct;
         av = ($urandom_range(99) < 60);
         cv = ($urandom_range(99) < 70);
         fl = ($urandom_range(99) < 3);
         if (mq.size() > 0 && $urandom_range(3) != 0)
            ct = mq[$urandom_range(mq.size() - 1)].tag;
         else
            ct = 4'($urandom_range(15));
         step(av, mk(5'($urandom_range(31))),
              4'($urandom_range(15)), cv, ct, $urandom, fl);
      end

      idle();
      idle();
      chk("commit_drain", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Parametrised circular reorder buffer holding DEPTH in-flight instructions.
- Successor to the single-entry ROB slot: adds internal head/tail management, tag-matched CDB capture, in-order single-commit, full/empty/count status and a global flush.
- Sits between the instruction handler (allocation) and the register file (commit write port); it snoops the common data bus.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- DATA_W, 32, result value width.
- TAG_W, 4, reservation-station/exe-unit tag width carried on the CDB.
- INSTR_W, 32, stored instruction width; dest field is instr[11:7].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- alloc_valid  input  1  instruction handler requests an entry.
- alloc_ready  output  1  equals ~full.
- alloc_instr  input  INSTR_W  instruction to log.
- alloc_tag  input  TAG_W  RS index producing this instruction's result.
- alloc_idx  output  log2(DEPTH)  ROB index granted; equals current tail.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  producing unit tag.
- cdb_value  input  DATA_W  broadcast result.
- flush  input  1  discard all entries.
- commit_valid  output  1  head entry retires this cycle.
- commit_we  output  1  commit_valid && commit_dest != 0.
- commit_dest  output  5  head instr[11:7].
- commit_value  output  DATA_W  retiring value.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, rst=1): all entries FREE, head = tail = 0, count = 0, stored value/instr/tag = 0. Outputs: empty = 1, full = 0, alloc_ready = 1, commit_valid = commit_we = 0, commit_dest = 0, commit_value = 0, alloc_idx = 0. Reset mid-operation discards everything immediately.
- Per-entry state: FREE -> WAIT (alloc) -> DONE (CDB capture) -> FREE (commit).
- Allocation:
  - alloc_valid && alloc_ready: entry[tail] <= {WAIT, instr, tag, value = 0}; tail <= tail + 1 mod DEPTH.
  - alloc_ready ignores a same-cycle commit; a full buffer refuses allocation even if the head retires.
- CDB capture: every WAIT entry with tag == cdb_tag captures cdb_value and goes to DONE at the next edge. An entry allocated in the same cycle does not capture (tag not yet resident).
- Commit (combinational outputs, at most one per cycle):
  - commit_valid = 1 if entry[head] is DONE, or if entry[head] is WAIT && cdb_valid && cdb_tag matches (bypass).
  - On bypass, commit_value = cdb_value; otherwise it is the stored value.
  - On commit: entry[head] <= FREE, instr cleared, head <= head + 1 mod DEPTH.
  - Empty buffer: commit_valid = 0.
  - When commit_valid = 0, commit_dest and commit_value are driven 0.
- Count: next count = count + alloc_fire - commit_fire. Simultaneous alloc and commit leaves count unchanged.
- Wrap-around: head and tail are log2(DEPTH) bits; full and empty are derived from count, never from pointer equality alone.
- Flush (synchronous, highest priority):
  - At the next edge, all entries FREE, head = tail = count = 0.
  - In the flush cycle, commit_valid and commit_we are forced to 0 and the allocation is dropped; alloc_ready is still shown.
- All sequential logic uses posedge clk or posedge rst.

Decomposition:
- Shared package rob_pkg: entry state localparams (ST_FREE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2), DEST_LSB=7, DEST_MSB=11.
- One sub-module, rob_slot:
  - Holds state, instr, tag and value for one entry.
  - Inputs: alloc_we, capture match, clear.
  - Outputs: state, tag, value, dest.
  - Instantiated DEPTH times via generate.
- Pointer, count and commit muxing live in the top module.

Test Plan:
- Reset then 3 allocs (tags 1, 2, 3; rd = 5, 6, 7) -> alloc_idx 0, 1, 2; count 3; empty 0; no commit.
- CDB tag 2, value 0xAA, then tag 1, value 0x55 -> cycle of tag 1: bypass commit rd=5, 0x55. Next cycle: commit rd=6, 0xAA from DONE entry. count ends at 1.
- Fill DEPTH=8 -> full = 1, alloc_ready = 0. Alloc attempted during a head commit is refused. Count goes 8 -> 7, then the next alloc succeeds at alloc_idx 0 (wrap).
- Alloc instruction with rd = 0, then CDB match -> commit_valid = 1, commit_we = 0.
- Flush with 5 entries, one of which is committing that cycle -> commit_valid = 0. Next cycle: count = 0, empty = 1, head = tail = 0.
- Assert rst asynchronously mid-cycle with 4 entries -> outputs reach reset values before the next clk edge; a subsequent alloc gets alloc_idx 0.
